// File: rtl/sparc_branch_pkg.sv
// Shared definitions for the SPARC Bicc branch sequencer.
//   state_t       : sequencer states (IDLE, DELAY, SQUASH)
//   COND_BN/BA    : condition codes that ignore the condition handler
//   branch_taken  : resolves the taken decision for a cond field
package sparc_branch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  localparam logic [3:0] COND_BN = 4'b0000;
  localparam logic [3:0] COND_BA = 4'b1000;

  // bn is never taken and ba always is; every other code defers to the
  // condition handler's evaluation of the integer condition codes.
  function automatic logic branch_taken(input logic [3:0] cond, input logic branch_out);
    logic result;
    if (cond == COND_BN) begin
      result = 1'b0;
    end else if (cond == COND_BA) begin
      result = 1'b1;
    end else begin
      result = branch_out;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Signal bundle for the branch sequencer's pipeline-side connections.
//   master : the pipeline (drives ID-stage branch info, stall, cnt_clr)
//   slave  : the sequencer view (drives pc_sel, target_out, flush, status)
interface branch_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             ID_branch_instr;
  logic [3:0]       ID_cond;
  logic             ID_annul;
  logic [PC_W-1:0]  ID_target;
  logic             branch_out;
  logic             cnt_clr;
  logic             pc_sel;
  logic [PC_W-1:0]  target_out;
  logic             flush_delay;
  logic             dcti_err;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] annul_cnt;

  modport master (
    output stall, ID_branch_instr, ID_cond, ID_annul, ID_target, branch_out, cnt_clr,
    input  pc_sel, target_out, flush_delay, dcti_err, busy, taken_cnt, annul_cnt
  );

  modport slave (
    input  stall, ID_branch_instr, ID_cond, ID_annul, ID_target, branch_out, cnt_clr,
    output pc_sel, target_out, flush_delay, dcti_err, busy, taken_cnt, annul_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : synchronous clear, takes priority over inc
//   inc          : count up by one, sticking at all-ones
//   count        : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/branch_sequencer.sv
// Branch sequencer for a SPARC-style pipeline with one delay slot.
// Accepts a Bicc in ID, redirects nPC for taken branches, squashes the
// delay slot for annulled branches, flags branches sitting in a live delay
// slot, and counts taken and annulled branches.
//   clk, reset_n       : clock, asynchronous active-low reset
//   stall              : pipeline hold; freezes the sequencer
//   ID_branch_instr    : branch present in ID
//   ID_cond, ID_annul  : cond field and annul bit of that branch
//   ID_target          : computed branch target
//   branch_out         : condition handler's taken decision
//   cnt_clr            : synchronous clear of both counters
//   pc_sel, target_out : nPC redirect and its registered target
//   flush_delay        : squash the delay-slot instruction in ID
//   dcti_err           : one-cycle pulse, branch in a live delay slot
//   busy               : sequencer not idle
//   taken_cnt, annul_cnt : saturating performance counters
module branch_sequencer
  import sparc_branch_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             ID_branch_instr,
  input  logic [3:0]       ID_cond,
  input  logic             ID_annul,
  input  logic [PC_W-1:0]  ID_target,
  input  logic             branch_out,
  input  logic             cnt_clr,
  output logic             pc_sel,
  output logic [PC_W-1:0]  target_out,
  output logic             flush_delay,
  output logic             dcti_err,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] annul_cnt
);

  state_t          state_reg, state_next;
  logic            pc_sel_reg, pc_sel_next;
  logic [PC_W-1:0] target_reg, target_next;
  // Registered annul decision of the accepted branch; it is exactly the
  // delay-slot squash request while the sequencer sits in SQUASH.
  logic            annul_q_reg, annul_q_next;
  logic            dcti_err_reg, dcti_err_next;

  logic taken;
  logic annul;
  logic accept;

  assign taken  = branch_taken(ID_cond, branch_out);
  // ba,a annuls its slot even though taken; conditional branches annul only
  // when not taken.
  assign annul  = ID_annul & ((ID_cond == COND_BA) | ~taken);
  assign accept = (state_reg == IDLE) & ID_branch_instr & ~stall;

  always_comb begin
    state_next    = state_reg;
    pc_sel_next   = pc_sel_reg;
    target_next   = target_reg;
    annul_q_next  = annul_q_reg;
    dcti_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          target_next  = ID_target;
          pc_sel_next  = taken;
          annul_q_next = annul;
          state_next   = annul ? SQUASH : DELAY;
        end
      end
      DELAY: begin
        if (!stall) begin
          // The slot instruction is live, so a branch here is a DCTI couple:
          // flag it and drop it rather than accepting it.
          dcti_err_next = ID_branch_instr;
          pc_sel_next   = 1'b0;
          annul_q_next  = 1'b0;
          state_next    = IDLE;
        end
      end
      SQUASH: begin
        // The slot is being flushed, so whatever sits in ID is dead.
        if (!stall) begin
          pc_sel_next  = 1'b0;
          annul_q_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: begin
        pc_sel_next  = 1'b0;
        annul_q_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      pc_sel_reg   <= 1'b0;
      target_reg   <= '0;
      annul_q_reg  <= 1'b0;
      dcti_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_sel_reg   <= pc_sel_next;
      target_reg   <= target_next;
      annul_q_reg  <= annul_q_next;
      dcti_err_reg <= dcti_err_next;
    end
  end

  assign pc_sel      = pc_sel_reg;
  assign target_out  = target_reg;
  assign flush_delay = annul_q_reg;
  assign dcti_err    = dcti_err_reg;
  assign busy        = (state_reg != IDLE);

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (accept & taken),
    .count   (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_annul_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (accept & annul),
    .count   (annul_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk;
  logic reset_n;

  branch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bif ();

  branch_sequencer #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (bif.stall),
    .ID_branch_instr (bif.ID_branch_instr),
    .ID_cond         (bif.ID_cond),
    .ID_annul        (bif.ID_annul),
    .ID_target       (bif.ID_target),
    .branch_out      (bif.branch_out),
    .cnt_clr         (bif.cnt_clr),
    .pc_sel          (bif.pc_sel),
    .target_out      (bif.target_out),
    .flush_delay     (bif.flush_delay),
    .dcti_err        (bif.dcti_err),
    .busy            (bif.busy),
    .taken_cnt       (bif.taken_cnt),
    .annul_cnt       (bif.annul_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A branch is "in flight" for the slot cycle(s) after it is accepted; the
  // slot is either executed (live) or squashed.
  bit          m_in_flight, m_slot_squashed, m_redirect, m_err;
  logic [31:0] m_tgt;
  int          m_tcnt, m_acnt;

  always @(posedge clk or negedge reset_n) begin
    bit tk, an;
    if (!reset_n) begin
      m_in_flight = 0; m_slot_squashed = 0; m_redirect = 0; m_err = 0;
      m_tgt = 0; m_tcnt = 0; m_acnt = 0;
    end else begin
      m_err = 0;
      if (!m_in_flight) begin
        if (bif.ID_branch_instr && !bif.stall) begin
          if (bif.ID_cond == 4'd0)      tk = 0;
          else if (bif.ID_cond == 4'd8) tk = 1;
          else                          tk = bif.branch_out;
          an = bif.ID_annul && (bif.ID_cond == 4'd8 || !tk);
          m_in_flight = 1; m_redirect = tk; m_slot_squashed = an;
          m_tgt = bif.ID_target;
          if (tk) m_tcnt = (m_tcnt < CMAX) ? m_tcnt + 1 : CMAX;
          if (an) m_acnt = (m_acnt < CMAX) ? m_acnt + 1 : CMAX;
          $display("accept cond=%0d taken=%0d annul=%0d target=0x%0h", bif.ID_cond, tk, an, bif.ID_target);
        end
      end else if (!bif.stall) begin
        if (!m_slot_squashed && bif.ID_branch_instr) m_err = 1;
        m_in_flight = 0; m_redirect = 0; m_slot_squashed = 0;
      end
      if (bif.cnt_clr) begin
        m_tcnt = 0; m_acnt = 0;
      end
    end
  end

  // Compare every cycle on the inactive edge.
  always @(negedge clk) begin
    check("pc_sel",      64'(bif.pc_sel),      64'(m_redirect));
    check("target_out",  64'(bif.target_out),  64'(m_tgt));
    check("flush_delay", 64'(bif.flush_delay), 64'(m_slot_squashed));
    check("dcti_err",    64'(bif.dcti_err),    64'(m_err));
    check("busy",        64'(bif.busy),        64'(m_in_flight));
    check("taken_cnt",   64'(bif.taken_cnt),   64'(m_tcnt));
    check("annul_cnt",   64'(bif.annul_cnt),   64'(m_acnt));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic instr, input logic [3:0] cond, input logic an,
                        input logic bout, input logic [31:0] tgt);
    bif.ID_branch_instr = instr;
    bif.ID_cond         = cond;
    bif.ID_annul        = an;
    bif.branch_out      = bout;
    bif.ID_target       = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bif.stall = 1'b0;
    bif.cnt_clr = 1'b0;
    set_br(0, 4'd0, 0, 0, 32'h0);
    #2;
    check("rst_pc_sel", 64'(bif.pc_sel), 64'd0);
    check("rst_flush", 64'(bif.flush_delay), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);
    check("rst_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    step();
    reset_n = 1'b1;

    // Annulled untaken conditional, first edge after reset; branch held in
    // ID through the squashed slot.
    $display("txn: bne,a untaken");
    set_br(1, 4'd1, 1, 0, 32'h0000_0200);
    step();
    check("r29_pc_sel", 64'(bif.pc_sel), 64'd0);
    check("r29_flush", 64'(bif.flush_delay), 64'd1);
    check("r29_annul_cnt", 64'(bif.annul_cnt), 64'd1);
    check("r29_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    step();
    check("squash_no_dcti", 64'(bif.dcti_err), 64'd0);
    check("squash_flush_1cyc", 64'(bif.flush_delay), 64'd0);
    check("return_edge_no_accept", 64'(bif.busy), 64'd0);
    set_br(0, 4'd1, 0, 0, 32'h0);

    $display("txn: ba target 0x400");
    set_br(1, 4'd8, 0, 0, 32'h0000_0400);
    step();
    check("r28_pc_sel", 64'(bif.pc_sel), 64'd1);
    check("r28_target", 64'(bif.target_out), 64'h400);
    check("r28_flush", 64'(bif.flush_delay), 64'd0);
    check("r28_taken_cnt", 64'(bif.taken_cnt), 64'd1);
    set_br(0, 4'd8, 0, 0, 32'h0);
    step();
    check("r28_pc_sel_drop", 64'(bif.pc_sel), 64'd0);

    $display("txn: bn with branch_out=1");
    set_br(1, 4'd0, 0, 1, 32'h0000_0500);
    step();
    check("r30_pc_sel", 64'(bif.pc_sel), 64'd0);
    check("r30_taken_cnt", 64'(bif.taken_cnt), 64'd1);
    check("r30_busy", 64'(bif.busy), 64'd1);
    set_br(0, 4'd0, 0, 0, 32'h0);
    step();

    $display("txn: ba,a with stalled squash slot");
    set_br(1, 4'd8, 1, 0, 32'h0000_0800);
    step();
    check("baa_pc_sel", 64'(bif.pc_sel), 64'd1);
    check("baa_flush", 64'(bif.flush_delay), 64'd1);
    bif.stall = 1'b1;
    set_br(0, 4'd8, 0, 0, 32'h0);
    step();
    step();
    check("baa_flush_held", 64'(bif.flush_delay), 64'd1);
    bif.stall = 1'b0;
    set_br(1, 4'd1, 0, 1, 32'h0000_0900);
    step();
    check("baa_slot_branch_no_dcti", 64'(bif.dcti_err), 64'd0);
    set_br(0, 4'd1, 0, 0, 32'h0);
    step();

    $display("txn: taken conditional with annul bit");
    set_br(1, 4'd1, 1, 1, 32'h0000_0a00);
    step();
    check("bne_a_taken_flush", 64'(bif.flush_delay), 64'd0);
    check("bne_a_taken_pc_sel", 64'(bif.pc_sel), 64'd1);
    set_br(0, 4'd1, 0, 0, 32'h0);
    step();

    $display("txn: branch in IDLE under stall");
    bif.stall = 1'b1;
    set_br(1, 4'd8, 0, 0, 32'h0000_0b00);
    step();
    check("stalled_no_accept", 64'(bif.busy), 64'd0);
    bif.stall = 1'b0;
    set_br(0, 4'd8, 0, 0, 32'h0);

    $display("txn: ba then 3 stalls then DCTI in slot");
    set_br(1, 4'd8, 0, 0, 32'h0000_1234);
    step();
    check("r31_pc_sel_c0", 64'(bif.pc_sel), 64'd1);
    bif.stall = 1'b1;
    set_br(0, 4'd8, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("r31_pc_sel_held", 64'(bif.pc_sel), 64'd1);
    end
    bif.stall = 1'b0;
    set_br(1, 4'd8, 0, 0, 32'h0000_2000);
    step();
    check("r31_dcti", 64'(bif.dcti_err), 64'd1);
    check("r31_pc_sel_off", 64'(bif.pc_sel), 64'd0);
    check("r31_target_kept", 64'(bif.target_out), 64'h1234);
    set_br(0, 4'd8, 0, 0, 32'h0);
    step();
    check("r31_dcti_pulse", 64'(bif.dcti_err), 64'd0);
    check("r31_no_second_accept", 64'(bif.taken_cnt), 64'd4);

    $display("txn: 17 ba,a accepts for saturation");
    for (int i = 0; i < 17; i++) begin
      set_br(1, 4'd8, 1, 0, 32'(i));
      step();
      set_br(0, 4'd8, 0, 0, 32'h0);
      step();
    end
    check("r32_taken_sat", 64'(bif.taken_cnt), 64'd15);
    check("r32_annul_sat", 64'(bif.annul_cnt), 64'd15);

    $display("txn: cnt_clr with simultaneous accept");
    bif.cnt_clr = 1'b1;
    set_br(1, 4'd8, 1, 0, 32'h0000_3000);
    step();
    check("r32_clr_taken", 64'(bif.taken_cnt), 64'd0);
    check("r32_clr_annul", 64'(bif.annul_cnt), 64'd0);
    check("r32_clr_accepted", 64'(bif.busy), 64'd1);
    bif.cnt_clr = 1'b0;
    bif.stall = 1'b1;
    set_br(0, 4'd8, 0, 0, 32'h0);
    step();
    check("r33_in_squash", 64'(bif.flush_delay), 64'd1);

    $display("txn: reset during SQUASH");
    reset_n = 1'b0;
    #1;
    check("r33_rst_pc_sel", 64'(bif.pc_sel), 64'd0);
    check("r33_rst_flush", 64'(bif.flush_delay), 64'd0);
    check("r33_rst_target", 64'(bif.target_out), 64'd0);
    check("r33_rst_busy", 64'(bif.busy), 64'd0);
    step();
    reset_n = 1'b1;
    bif.stall = 1'b0;
    step();
    check("r33_post_flush", 64'(bif.flush_delay), 64'd0);
    check("r33_post_pc_sel", 64'(bif.pc_sel), 64'd0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
